// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-size helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'd0;
    localparam logic [2:0] F3_H   = 3'd1;
    localparam logic [2:0] F3_W   = 3'd2;
    localparam logic [2:0] F3_BU  = 3'd4;
    localparam logic [2:0] F3_HU  = 3'd5;

    localparam logic [2:0] MEM_SB = 3'd0;
    localparam logic [2:0] MEM_SW = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SH_LO,
        RESP
    } lsu_state_t;

    // Bytes touched by an access; the low two funct3 bits encode the width.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    access_size = 3'd1;
            2'd1:    access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface load_store_unit_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [2:0]  REQ_FUNCT3;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );
endinterface

// File: rtl/load_store_unit_formatter.sv
// Extracts and extends load data from a big-endian memory word (addressed byte in [31:24]).
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] MEM_READ_DATA,
    input  logic [2:0]  FUNCT3,
    output logic [31:0] LOAD_DATA
);

    always_comb begin
        LOAD_DATA = MEM_READ_DATA;
        case (FUNCT3)
            F3_B:    LOAD_DATA = {{24{MEM_READ_DATA[31]}}, MEM_READ_DATA[31:24]};
            F3_BU:   LOAD_DATA = {24'd0, MEM_READ_DATA[31:24]};
            F3_H:    LOAD_DATA = {{16{MEM_READ_DATA[31]}}, MEM_READ_DATA[31:16]};
            F3_HU:   LOAD_DATA = {16'd0, MEM_READ_DATA[31:16]};
            default: LOAD_DATA = MEM_READ_DATA;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for the big-endian data memory; sh is issued as two sb writes.
// Define LSU_STATS_EN to add saturating LOAD_COUNT/STORE_COUNT/ERR_COUNT outputs.
//
// state  | meaning
// IDLE   | ready for a request; errored requests go straight to RESP
// ACCESS | memory cycle at addr (load sample, sw/sb write, sh high byte)
// SH_LO  | sh low byte written at addr+1
// RESP   | response held until RSP_READY
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1025
) (
    input  logic               CLK,
    input  logic               RST_N,
    load_store_unit_if.slave   lsu,
    output logic               MEM_WE,
    output logic [2:0]         MEM_FUNCT3,
    output logic [31:0]        MEM_ADDRESS,
    output logic [31:0]        MEM_WRITE_DATA,
    input  logic [31:0]        MEM_READ_DATA
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]        LOAD_COUNT,
    output logic [15:0]        STORE_COUNT,
    output logic [15:0]        ERR_COUNT
`endif
);

    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_ready;
    logic        accept;
    logic        bad_funct3;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] last_addr;
    logic [31:0] load_data;

    assign req_ready = RST_N && (state_q == IDLE);
    assign accept    = lsu.REQ_VALID && req_ready;

    assign bad_funct3 = lsu.REQ_WE ? (lsu.REQ_FUNCT3 > F3_W)
                                   : (lsu.REQ_FUNCT3 == 3'd3 || lsu.REQ_FUNCT3 > F3_HU);
    assign misaligned = (lsu.REQ_FUNCT3[1:0] == 2'd1 && lsu.REQ_ADDR[0]) ||
                        (lsu.REQ_FUNCT3[1:0] == 2'd2 && lsu.REQ_ADDR[1:0] != 2'd0);
    // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap back into range.
    assign last_addr    = {1'b0, lsu.REQ_ADDR} + 33'(access_size(lsu.REQ_FUNCT3)) - 33'd1;
    assign out_of_range = last_addr > LAST_BYTE;
    assign req_err      = bad_funct3 || misaligned || out_of_range;

    load_formatter u_fmt (
        .MEM_READ_DATA (MEM_READ_DATA),
        .FUNCT3        (f3_q),
        .LOAD_DATA     (load_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        MEM_WE         = 1'b0;
        MEM_FUNCT3     = MEM_SW;
        MEM_ADDRESS    = addr_q;
        MEM_WRITE_DATA = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (we_q) begin
                    MEM_WE = 1'b1;
                    if (f3_q == F3_W) begin
                        MEM_WRITE_DATA = wdata_q;
                    end else begin
                        MEM_FUNCT3 = MEM_SB;
                        // Big-endian: the high byte of a halfword lives at the lower address.
                        if (f3_q == F3_H) begin
                            MEM_WRITE_DATA = {24'd0, wdata_q[15:8]};
                            state_d        = SH_LO;
                        end else begin
                            MEM_WRITE_DATA = {24'd0, wdata_q[7:0]};
                        end
                    end
                end
            end
            SH_LO: begin
                MEM_WE         = 1'b1;
                MEM_FUNCT3     = MEM_SB;
                MEM_ADDRESS    = addr_q + 32'd1;
                MEM_WRITE_DATA = {24'd0, wdata_q[7:0]};
                state_d        = RESP;
            end
            RESP: begin
                if (lsu.RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= lsu.REQ_WE;
            f3_q    <= lsu.REQ_FUNCT3;
            addr_q  <= lsu.REQ_ADDR;
            wdata_q <= lsu.REQ_WDATA;
            rdata_q <= 32'd0;
            err_q   <= req_err;
        end else if (state_q == ACCESS && !we_q) begin
            rdata_q <= load_data;
        end
    end

    assign lsu.REQ_READY = req_ready;
    assign lsu.RSP_VALID = (state_q == RESP);
    assign lsu.RSP_RDATA = rdata_q;
    assign lsu.RSP_ERR   = err_q;

`ifdef LSU_STATS_EN
    logic rsp_hs;
    assign rsp_hs = (state_q == RESP) && lsu.RSP_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LOAD_COUNT  <= 16'd0;
            STORE_COUNT <= 16'd0;
            ERR_COUNT   <= 16'd0;
        end else if (rsp_hs) begin
            if (err_q) begin
                if (ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
            end else if (we_q) begin
                if (STORE_COUNT != 16'hFFFF) STORE_COUNT <= STORE_COUNT + 16'd1;
            end else begin
                if (LOAD_COUNT != 16'hFFFF) LOAD_COUNT <= LOAD_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule
